// File: rtl/vram_engine_arbiter.sv
// VRAM port A owner: arbitrates CPU Avalon accesses against a fill/scroll engine
// that clears the text screen or scrolls it up one row and blanks the last row.
module vram_engine_arbiter #(
   parameter int ADDR_W        = 11,
   parameter int WORDS_PER_ROW = 40,
   parameter int ROWS          = 30,
   parameter int MAX_CPU_BURST = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cpu_read,
   input  logic              i_cpu_write,
   input  logic [3:0]        i_cpu_byte_en,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [31:0]       i_cpu_writedata,
   output logic              o_cpu_waitrequest,
   output logic [31:0]       o_cpu_readdata,
   output logic              o_cpu_readdatavalid,
   input  logic              i_csr_read,
   input  logic              i_csr_write,
   input  logic              i_csr_addr,
   input  logic [31:0]       i_csr_writedata,
   output logic [31:0]       o_csr_readdata,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [3:0]        o_ram_byte_en,
   output logic [31:0]       o_ram_wdata,
   output logic              o_ram_rden,
   output logic              o_ram_wren,
   input  logic [31:0]       i_ram_q,
   output logic              o_done_irq
);

   localparam int RUN_W = $clog2(MAX_CPU_BURST + 1);
   localparam logic [ADDR_W-1:0] L_LAST_WORD = ADDR_W'(ROWS * WORDS_PER_ROW - 1);
   localparam logic [ADDR_W-1:0] L_SCR_LAST  = ADDR_W'((ROWS - 1) * WORDS_PER_ROW - 1);
   localparam logic [ADDR_W-1:0] L_WPR       = ADDR_W'(WORDS_PER_ROW);
   localparam logic [ADDR_W-1:0] L_IDX_ONE   = ADDR_W'(1);
   localparam logic [RUN_W-1:0]  L_MAX_RUN   = RUN_W'(MAX_CPU_BURST);
   localparam logic [RUN_W-1:0]  L_RUN_ONE   = RUN_W'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FILL      = 3'd1,
      S_SCR_RD    = 3'd2,
      S_SCR_WAIT  = 3'd3,
      S_SCR_WR    = 3'd4,
      S_FILL_LAST = 3'd5
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_idx;
   logic [31:0]       r_sbuf;
   logic [31:0]       r_fill_data;
   logic [31:0]       r_csr_readdata;
   logic [RUN_W-1:0]  r_cpu_run;
   logic              r_done;
   logic              r_cpu_rdv;

   logic              w_cpu_req;
   logic              w_eng_req;
   logic              w_eng_rd;
   logic              w_cpu_grant;
   logic              w_eng_grant;
   logic              w_busy;
   logic              w_ctrl_wr;
   logic              w_start;
   logic [ADDR_W-1:0] w_eng_addr;
   logic [31:0]       w_eng_wdata;

   assign w_busy    = (r_state != S_IDLE);
   assign w_cpu_req = i_cpu_read | i_cpu_write;
   assign w_ctrl_wr = i_csr_write & ~i_csr_addr;
   assign w_start   = w_ctrl_wr & ~w_busy & (i_csr_writedata[0] | i_csr_writedata[1]);

   // Engine beat request decoded from the current state; SCR_WAIT deliberately leaves the port to the CPU
   always_comb begin
      w_eng_req   = 1'b0;
      w_eng_rd    = 1'b0;
      w_eng_addr  = r_idx;
      w_eng_wdata = r_fill_data;
      case (r_state)
         S_FILL, S_FILL_LAST: begin
            w_eng_req = 1'b1;
         end
         S_SCR_RD: begin
            w_eng_req  = 1'b1;
            w_eng_rd   = 1'b1;
            w_eng_addr = r_idx + L_WPR;
         end
         S_SCR_WR: begin
            w_eng_req   = 1'b1;
            w_eng_wdata = r_sbuf;
         end
         default: begin
            w_eng_req = 1'b0;
         end
      endcase
   end

   assign w_cpu_grant = w_cpu_req & ~i_rst & ~(w_eng_req & (r_cpu_run == L_MAX_RUN));
   assign w_eng_grant = w_eng_req & ~i_rst & ~w_cpu_grant;

   assign o_cpu_waitrequest   = i_rst | (w_cpu_req & ~w_cpu_grant);
   assign o_cpu_readdata      = i_ram_q;
   assign o_cpu_readdatavalid = r_cpu_rdv;
   assign o_csr_readdata      = r_csr_readdata;
   assign o_done_irq          = r_done;

   // Port A drive mux: the granted requester owns the port, everything is zero when idle
   always_comb begin
      o_ram_addr    = {ADDR_W{1'b0}};
      o_ram_byte_en = 4'b0000;
      o_ram_wdata   = 32'h0000_0000;
      o_ram_rden    = 1'b0;
      o_ram_wren    = 1'b0;
      if (w_cpu_grant) begin
         o_ram_addr    = i_cpu_addr;
         o_ram_byte_en = i_cpu_byte_en;
         if (i_cpu_write) begin
            o_ram_wren  = 1'b1;
            o_ram_wdata = i_cpu_writedata;
         end else begin
            o_ram_rden  = 1'b1;
         end
      end else if (w_eng_grant) begin
         o_ram_addr = w_eng_addr;
         if (w_eng_rd) begin
            o_ram_rden = 1'b1;
         end else begin
            o_ram_wren    = 1'b1;
            o_ram_byte_en = 4'b1111;
            o_ram_wdata   = w_eng_wdata;
         end
      end else begin
         o_ram_addr = {ADDR_W{1'b0}};
      end
   end

   // CPU burst counter bounds how long a waiting engine can be starved; read-valid tracks grants
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cpu_run <= {RUN_W{1'b0}};
         r_cpu_rdv <= 1'b0;
      end else begin
         r_cpu_rdv <= w_cpu_grant & i_cpu_read & ~i_cpu_write;
         if (!w_eng_req || w_eng_grant) begin
            r_cpu_run <= {RUN_W{1'b0}};
         end else if (w_cpu_grant) begin
            r_cpu_run <= r_cpu_run + L_RUN_ONE;
         end else begin
            r_cpu_run <= r_cpu_run;
         end
      end
   end

   // CSR file and engine sequencer; a completing op sets DONE even if a clear lands the same cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state        <= S_IDLE;
         r_idx          <= {ADDR_W{1'b0}};
         r_sbuf         <= 32'h0000_0000;
         r_fill_data    <= 32'h0000_0000;
         r_csr_readdata <= 32'h0000_0000;
         r_done         <= 1'b0;
      end else begin
         if (i_csr_read) begin
            r_csr_readdata <= i_csr_addr ? r_fill_data : {30'b0, r_done, w_busy};
         end else begin
            r_csr_readdata <= 32'h0000_0000;
         end
         if (i_csr_write && i_csr_addr) begin
            r_fill_data <= i_csr_writedata;
         end
         if (w_ctrl_wr && i_csr_writedata[2]) begin
            r_done <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_done  <= 1'b0;
                  r_idx   <= {ADDR_W{1'b0}};
                  r_state <= i_csr_writedata[0] ? S_FILL : S_SCR_RD;
               end
            end
            S_FILL, S_FILL_LAST: begin
               if (w_eng_grant) begin
                  if (r_idx == L_LAST_WORD) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                     r_idx   <= {ADDR_W{1'b0}};
                  end else begin
                     r_idx <= r_idx + L_IDX_ONE;
                  end
               end
            end
            S_SCR_RD: begin
               if (w_eng_grant) begin
                  r_state <= S_SCR_WAIT;
               end
            end
            S_SCR_WAIT: begin
               r_sbuf  <= i_ram_q;
               r_state <= S_SCR_WR;
            end
            S_SCR_WR: begin
               if (w_eng_grant) begin
                  r_idx   <= r_idx + L_IDX_ONE;
                  r_state <= (r_idx == L_SCR_LAST) ? S_FILL_LAST : S_SCR_RD;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vram_engine_arbiter.sv
// Randomized bench for vram_engine_arbiter: bench-side VRAM plus a beat-queue reference
// model checked every cycle, with directed scenarios pinned by hand-computed numbers.
module tb_vram_engine_arbiter;

   localparam int WORDS = 1200;
   localparam int WPR   = 40;
   localparam int SCR_N = 1160;
   localparam int MAXB  = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_read, cpu_write;
   logic [3:0]  cpu_be;
   logic [10:0] cpu_addr;
   logic [31:0] cpu_wd;
   logic        waitreq;
   logic [31:0] cpu_rdata;
   logic        cpu_rdv;
   logic        csr_read, csr_write, csr_addr;
   logic [31:0] csr_wd, csr_rdata;
   logic [10:0] ram_addr;
   logic [3:0]  ram_be;
   logic [31:0] ram_wdata, ram_q;
   logic        ram_rden, ram_wren;
   logic        done_irq;

   always #10 clk = ~clk;

   vram_engine_arbiter #(.ADDR_W(11), .WORDS_PER_ROW(WPR), .ROWS(30), .MAX_CPU_BURST(MAXB)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_cpu_read(cpu_read), .i_cpu_write(cpu_write), .i_cpu_byte_en(cpu_be),
      .i_cpu_addr(cpu_addr), .i_cpu_writedata(cpu_wd),
      .o_cpu_waitrequest(waitreq), .o_cpu_readdata(cpu_rdata), .o_cpu_readdatavalid(cpu_rdv),
      .i_csr_read(csr_read), .i_csr_write(csr_write), .i_csr_addr(csr_addr),
      .i_csr_writedata(csr_wd), .o_csr_readdata(csr_rdata),
      .o_ram_addr(ram_addr), .o_ram_byte_en(ram_be), .o_ram_wdata(ram_wdata),
      .o_ram_rden(ram_rden), .o_ram_wren(ram_wren), .i_ram_q(ram_q),
      .o_done_irq(done_irq)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Bench-side VRAM port A: byte-enabled writes, one-cycle read latency
   logic [31:0] vram [0:WORDS-1];
   logic        do_preload = 1'b0;
   always @(posedge clk) begin
      if (do_preload) begin
         for (int i = 0; i < WORDS; i++) vram[i] <= 32'(i);
      end else if (ram_wren && ram_addr < 11'(WORDS)) begin
         for (int b = 0; b < 4; b++)
            if (ram_be[b]) vram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      if (ram_rden && ram_addr < 11'(WORDS)) ram_q <= vram[ram_addr];
   end

   // Reference model: the engine's work is a queue of RAM beats built when an op starts
   typedef struct packed { logic rd; logic src; logic [10:0] addr; } beat_t;
   beat_t       eq [$];
   logic [31:0] model_mem [0:WORDS-1];
   logic [31:0] m_fill = 32'h0, m_sbuf = 32'h0, m_rd_exp = 32'h0, m_csr_exp = 32'h0;
   logic        m_done = 1'b0, m_busy = 1'b0, m_wait = 1'b0, m_rdv_pend = 1'b0, m_csr_pend = 1'b0;
   int          m_run = 0;
   int          m_eng_wr_cnt = 0;
   logic        cpu_acc = 1'b0;

   function automatic beat_t mk(input logic rd, input logic src, input int a);
      beat_t b;
      b.rd = rd; b.src = src; b.addr = 11'(a);
      return b;
   endfunction

   always @(negedge clk) begin
      logic cpu_req, eng_req, cg, eg, busy_now, exp_rd, exp_wr;
      logic [10:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      beat_t hd;
      if (rst) begin
         chk("rst_waitreq", 64'(waitreq), 64'(1));
         chk("rst_strobes", 64'({ram_rden, ram_wren}), 64'(0));
         chk("rst_rdvalid", 64'(cpu_rdv), 64'(0));
         chk("rst_done", 64'(done_irq), 64'(0));
         chk("rst_csr_rdata", 64'(csr_rdata), 64'(0));
         eq.delete();
         m_fill = 32'h0; m_done = 1'b0; m_busy = 1'b0; m_wait = 1'b0;
         m_run = 0; m_rdv_pend = 1'b0; m_csr_pend = 1'b0; cpu_acc = 1'b0;
      end else begin
         if (do_preload) for (int i = 0; i < WORDS; i++) model_mem[i] = 32'(i);
         cpu_req = cpu_read | cpu_write;
         eng_req = (eq.size() != 0) && !m_wait;
         cg = cpu_req && !(eng_req && m_run == MAXB);
         eg = eng_req && !cg;
         chk("waitreq", 64'(waitreq), 64'(cpu_req && !cg));
         chk("rdvalid", 64'(cpu_rdv), 64'(m_rdv_pend));
         if (m_rdv_pend) chk("cpu_rddata", 64'(cpu_rdata), 64'(m_rd_exp));
         if (m_csr_pend) chk("csr_rddata", 64'(csr_rdata), 64'(m_csr_exp));
         chk("done_irq", 64'(done_irq), 64'(m_done));
         exp_rd = 1'b0; exp_wr = 1'b0; exp_addr = 11'd0; exp_be = 4'd0; exp_wd = 32'd0;
         hd = mk(1'b0, 1'b0, 0);
         if (cg) begin
            exp_addr = cpu_addr;
            if (cpu_write) begin exp_wr = 1'b1; exp_be = cpu_be; exp_wd = cpu_wd; end
            else exp_rd = 1'b1;
         end else if (eg) begin
            hd = eq[0];
            exp_addr = hd.addr;
            if (hd.rd) exp_rd = 1'b1;
            else begin exp_wr = 1'b1; exp_be = 4'hF; exp_wd = hd.src ? m_sbuf : m_fill; end
         end
         chk("ram_strobes", 64'({ram_rden, ram_wren}), 64'({exp_rd, exp_wr}));
         if (exp_rd || exp_wr) chk("ram_addr", 64'(ram_addr), 64'(exp_addr));
         if (exp_wr) chk("ram_be_wdata", 64'({ram_be, ram_wdata}), 64'({exp_be, exp_wd}));
         cpu_acc = cpu_req && !waitreq;
         // advance the model to the next cycle
         busy_now = m_busy;
         m_csr_pend = csr_read;
         if (csr_read) m_csr_exp = csr_addr ? m_fill : {30'b0, m_done, m_busy};
         if (csr_write && !csr_addr && csr_wd[2]) m_done = 1'b0;
         m_rdv_pend = cg && cpu_read && !cpu_write;
         if (cg && cpu_read && !cpu_write) m_rd_exp = model_mem[cpu_addr];
         if (cg && cpu_write)
            for (int b = 0; b < 4; b++)
               if (cpu_be[b]) model_mem[cpu_addr][8*b +: 8] = cpu_wd[8*b +: 8];
         if (eg) begin
            if (hd.rd) begin m_sbuf = model_mem[hd.addr]; m_wait = 1'b1; end
            else begin model_mem[hd.addr] = exp_wd; m_eng_wr_cnt++; end
            void'(eq.pop_front());
            if (eq.size() == 0) begin m_done = 1'b1; m_busy = 1'b0; end
         end else begin
            m_wait = 1'b0;
         end
         if (eng_req) begin
            if (eg) m_run = 0;
            else if (cg) m_run++;
         end else begin
            m_run = 0;
         end
         if (csr_write && csr_addr) m_fill = csr_wd;
         if (csr_write && !csr_addr && !busy_now && (csr_wd[1:0] != 2'b00)) begin
            m_done = 1'b0; m_busy = 1'b1; eq.delete();
            if (csr_wd[0]) begin
               for (int i = 0; i < WORDS; i++) eq.push_back(mk(1'b0, 1'b0, i));
            end else begin
               for (int i = 0; i < SCR_N; i++) begin
                  eq.push_back(mk(1'b1, 1'b0, i + WPR));
                  eq.push_back(mk(1'b0, 1'b1, i));
               end
               for (int i = SCR_N; i < WORDS; i++) eq.push_back(mk(1'b0, 1'b0, i));
            end
         end
      end
   end

   // CPU master: holds each request until accepted; mode 0 idle, 1 sequential reads, 2 random
   int cpu_mode = 0;
   int seq_addr = 0;
   initial begin
      cpu_read = 1'b0; cpu_write = 1'b0; cpu_be = 4'h0; cpu_addr = 11'd0; cpu_wd = 32'h0;
      forever begin
         @(posedge clk); #1;
         if (!(cpu_read || cpu_write) || cpu_acc) begin
            cpu_read = 1'b0; cpu_write = 1'b0;
            if (cpu_mode == 1) begin
               cpu_read = 1'b1; cpu_be = 4'hF; cpu_addr = 11'(seq_addr);
               seq_addr = (seq_addr == WORDS - 1) ? 0 : seq_addr + 1;
            end else if (cpu_mode == 2) begin
               int r;
               r = int'($urandom_range(0, 3));
               cpu_addr = 11'($urandom_range(0, WORDS - 1));
               cpu_be   = 4'($urandom_range(1, 15));
               cpu_wd   = $urandom;
               if (r == 1) cpu_read = 1'b1;
               else if (r == 2) cpu_write = 1'b1;
            end
         end
      end
   end

   task automatic csr_wr(input logic a, input logic [31:0] d);
      csr_write = 1'b1; csr_addr = a; csr_wd = d;
      @(posedge clk); #1;
      csr_write = 1'b0; csr_wd = 32'h0;
   endtask

   task automatic csr_rd(input logic a, output logic [31:0] d);
      csr_read = 1'b1; csr_addr = a;
      @(posedge clk); #1;
      csr_read = 1'b0;
      d = csr_rdata;
   endtask

   task automatic preload();
      do_preload = 1'b1;
      @(posedge clk); #1;
      do_preload = 1'b0;
   endtask

   // Counts cycles from the op's first cycle until DONE shows, plus write/stall cycles in between
   task automatic run_op(output int cyc, output int wrn, output int wt);
      int n;
      n = 0; wrn = 0; wt = 0;
      while (1) begin
         @(negedge clk);
         n++;
         if (done_irq) break;
         if (ram_wren) wrn++;
         if (waitreq) wt++;
         if (n > 40000) begin
            chk("op_timeout", 64'(done_irq), 64'(1));
            break;
         end
      end
      cyc = n - 1;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] d;
      int cyc, wrn, wt, base, n, bad;
      rst = 1'b1; csr_read = 1'b0; csr_write = 1'b0; csr_addr = 1'b0; csr_wd = 32'h0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      preload();

      // CSR access
      csr_wr(1'b1, 32'hA5A5_1234);
      csr_rd(1'b1, d);
      chk("fill_data_rd", 64'(d), 64'hA5A5_1234);
      csr_rd(1'b0, d);
      chk("ctrl_idle_rd", 64'(d), 64'h0);

      // Plain fill with no CPU traffic
      csr_wr(1'b1, 32'h0F20_0F20);
      csr_wr(1'b0, 32'h1);
      run_op(cyc, wrn, wt);
      chk("fill_cycles", 64'(cyc), 64'd1200);
      chk("fill_wren_cycles", 64'(wrn), 64'd1200);
      chk("fill_word0", 64'(vram[0]), 64'h0F20_0F20);
      chk("fill_word1199", 64'(vram[1199]), 64'h0F20_0F20);

      // Scroll over word[i]=i
      preload();
      csr_wr(1'b1, 32'h0020_0020);
      csr_wr(1'b0, 32'h2);
      run_op(cyc, wrn, wt);
      chk("scroll_cycles", 64'(cyc), 64'd3520);
      chk("scroll_writes", 64'(wrn), 64'd1200);
      chk("scroll_word0", 64'(vram[0]), 64'd40);
      chk("scroll_word1159", 64'(vram[1159]), 64'd1199);
      chk("scroll_word1160", 64'(vram[1160]), 64'h0020_0020);
      chk("scroll_word1199", 64'(vram[1199]), 64'h0020_0020);

      // Back-to-back CPU reads during fill: engine gets every 9th cycle
      preload();
      csr_wr(1'b1, 32'h1234_5678);
      cpu_mode = 1;
      repeat (5) @(posedge clk);
      #1 csr_wr(1'b0, 32'h1);
      run_op(cyc, wrn, wt);
      cpu_mode = 0;
      chk("burst_fill_cycles", 64'(cyc), 64'd10800);
      chk("burst_stall_cycles", 64'(wt), 64'd1200);
      repeat (4) @(posedge clk);
      #1 chk("burst_word600", 64'(vram[600]), 64'h1234_5678);

      // CTRL=3 runs FILL, start while busy ignored, CTRL=4 clears DONE
      csr_wr(1'b1, 32'h1111_2222);
      csr_wr(1'b0, 32'h3);
      repeat (5) @(posedge clk);
      #1 csr_rd(1'b0, d);
      chk("ctrl_busy_rd", 64'(d), 64'h1);
      csr_wr(1'b0, 32'h2);
      run_op(cyc, wrn, wt);
      csr_rd(1'b0, d);
      chk("ctrl_done_rd", 64'(d), 64'h2);
      chk("ctrl3_word3", 64'(vram[3]), 64'h1111_2222);
      csr_wr(1'b0, 32'h4);
      csr_rd(1'b0, d);
      chk("ctrl_clear_rd", 64'(d), 64'h0);
      chk("ctrl_clear_irq", 64'(done_irq), 64'h0);

      // Reset in the middle of a scroll
      preload();
      csr_wr(1'b1, 32'hDEAD_BEEF);
      base = m_eng_wr_cnt;
      csr_wr(1'b0, 32'h2);
      n = 0;
      while ((m_eng_wr_cnt - base) < 500 && n < 5000) begin @(negedge clk); n++; end
      chk("scroll_reached_500", 64'(m_eng_wr_cnt - base >= 500), 64'(1));
      @(posedge clk); #2 rst = 1'b1;
      #1 chk("rst_async_wren", 64'(ram_wren), 64'(0));
      chk("rst_async_irq", 64'(done_irq), 64'(0));
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      wrn = 0;
      for (int i = 0; i < 20; i++) begin @(negedge clk); if (ram_wren) wrn++; end
      chk("post_rst_writes", 64'(wrn), 64'(0));
      @(posedge clk); #1 csr_rd(1'b0, d);
      chk("post_rst_ctrl", 64'(d), 64'h0);

      // Random CPU traffic with random CSR activity
      cpu_mode = 2;
      for (int k = 0; k < 8000; k++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 3) csr_wr(1'b1, $urandom);
         else if (r < 5) csr_wr(1'b0, 32'($urandom_range(0, 7)));
         else if (r < 10) csr_rd(1'($urandom_range(0, 1)), d);
         else begin @(posedge clk); #1; end
      end
      cpu_mode = 0;
      n = 0;
      while (m_busy && n < 40000) begin @(posedge clk); n++; end
      chk("random_drain", 64'(m_busy), 64'(0));
      repeat (5) @(posedge clk);
      #1 bad = 0;
      for (int i = 0; i < WORDS; i++) if (vram[i] !== model_mem[i]) bad++;
      chk("final_mem_words_differing", 64'(bad), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
